// File: rtl/pic_cmd_seq_if.sv
// CPU-side bus of the interrupt controller: strobes, address, write data in,
// registered read data and pad enable out.
interface pic_cmd_seq_if;
  logic       csn;
  logic       rdn;
  logic       wrn;
  logic       a0;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (output csn, rdn, wrn, a0, d_in, input d_out, d_oe);
  modport slave  (input csn, rdn, wrn, a0, d_in, output d_out, d_oe);
endinterface

// File: rtl/pic_cmd_seq.sv
// Command-word sequencer: ICW1..ICW4 initialisation, OCW1..OCW3 handling and
// byte-sequenced IRR/ISR/IMR status reads for NIRQ/8 bytes per vector.
module pic_cmd_seq #(
  parameter int NIRQ = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pic_cmd_seq_if.slave    bus,
  input  logic [NIRQ-1:0] irr,
  input  logic [NIRQ-1:0] isr,
  output logic [NIRQ-1:0] imr,
  output logic [4:0]      vec_base,
  output logic [7:0]      icw3,
  output logic            ltim,
  output logic            sngl,
  output logic            ic4,
  output logic            upm,
  output logic            aeoi,
  output logic            ms,
  output logic            buf_mode,
  output logic            sfnm,
  output logic [7:0]      ocw2_cmd,
  output logic            ocw2_stb,
  output logic            smm,
  output logic            ris,
  output logic            init_done
);

  localparam int NB = NIRQ / 8;
  localparam int PW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [2:0] {IDLE, W_ICW2, W_ICW3, W_ICW4, READY} state_t;

  state_t          state_q, state_d;
  logic            wr_q, rd_q;
  logic            a_lat_q, a_lat_d;
  logic [7:0]      d_lat_q, d_lat_d;
  logic [PW-1:0]   ptr_q, ptr_d, ptr_inc;
  logic [NIRQ-1:0] imr_q, imr_d;
  logic [4:0]      vec_base_q, vec_base_d;
  logic [7:0]      icw3_q, icw3_d;
  logic            ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
  logic [4:0]      icw4_q, icw4_d;
  logic [7:0]      ocw2_cmd_q, ocw2_cmd_d;
  logic            ocw2_stb_q, ocw2_stb_d;
  logic            smm_q, smm_d, ris_q, ris_d;
  logic            init_done_q, init_done_d;
  logic [7:0]      d_out_q, d_out_d, rd_byte;

  logic wr_act, rd_act, wr_commit, rd_commit;

  // A write strobe alone qualifies a write; a read needs wrn high so a
  // simultaneous read/write is treated as a write.
  assign wr_act    = ~bus.csn & ~bus.wrn;
  assign rd_act    = ~bus.csn & ~bus.rdn & bus.wrn;
  assign wr_commit = wr_q & ~wr_act;
  assign rd_commit = rd_q & ~rd_act;

  assign ptr_inc = (ptr_q == PW'(NB - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    rd_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (ptr_q == PW'(i)) begin
        if (bus.a0)     rd_byte = imr_q[8*i +: 8];
        else if (ris_q) rd_byte = isr[8*i +: 8];
        else            rd_byte = irr[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    a_lat_d     = wr_act ? bus.a0   : a_lat_q;
    d_lat_d     = wr_act ? bus.d_in : d_lat_q;
    d_out_d     = rd_act ? rd_byte  : d_out_q;
    ptr_d       = ptr_q;
    imr_d       = imr_q;
    vec_base_d  = vec_base_q;
    icw3_d      = icw3_q;
    ltim_d      = ltim_q;
    sngl_d      = sngl_q;
    ic4_d       = ic4_q;
    icw4_d      = icw4_q;
    ocw2_cmd_d  = ocw2_cmd_q;
    ocw2_stb_d  = 1'b0;
    smm_d       = smm_q;
    ris_d       = ris_q;

    if (wr_commit) begin
      if (!a_lat_q && d_lat_q[4]) begin
        ltim_d  = d_lat_q[3];
        sngl_d  = d_lat_q[1];
        ic4_d   = d_lat_q[0];
        imr_d   = '0;
        smm_d   = 1'b0;
        ris_d   = 1'b0;
        ptr_d   = '0;
        if (!d_lat_q[0]) icw4_d = '0;
        state_d = W_ICW2;
      end else begin
        case (state_q)
          W_ICW2: if (a_lat_q) begin
            vec_base_d = d_lat_q[7:3];
            if (!sngl_q)   state_d = W_ICW3;
            else if (ic4_q) state_d = W_ICW4;
            else            state_d = READY;
          end
          W_ICW3: if (a_lat_q) begin
            icw3_d  = d_lat_q;
            state_d = ic4_q ? W_ICW4 : READY;
          end
          W_ICW4: if (a_lat_q) begin
            icw4_d  = d_lat_q[4:0];
            state_d = READY;
          end
          READY: begin
            if (a_lat_q) begin
              for (int i = 0; i < NB; i++) begin
                if (ptr_q == PW'(i)) imr_d[8*i +: 8] = d_lat_q;
              end
              ptr_d = ptr_inc;
            end else if (d_lat_q[4:3] == 2'b00) begin
              ocw2_cmd_d = d_lat_q;
              ocw2_stb_d = 1'b1;
              ptr_d      = '0;
            end else begin
              if (d_lat_q[1]) ris_d = d_lat_q[0];
              if (d_lat_q[6]) smm_d = d_lat_q[5];
              ptr_d = '0;
            end
          end
          default: ;
        endcase
      end
    end else if (rd_commit) begin
      ptr_d = ptr_inc;
    end

    init_done_d = (state_d == READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      a_lat_q     <= 1'b0;
      d_lat_q     <= '0;
      d_out_q     <= '0;
      ptr_q       <= '0;
      imr_q       <= '0;
      vec_base_q  <= '0;
      icw3_q      <= '0;
      ltim_q      <= 1'b0;
      sngl_q      <= 1'b0;
      ic4_q       <= 1'b0;
      icw4_q      <= '0;
      ocw2_cmd_q  <= '0;
      ocw2_stb_q  <= 1'b0;
      smm_q       <= 1'b0;
      ris_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_act;
      rd_q        <= rd_act;
      a_lat_q     <= a_lat_d;
      d_lat_q     <= d_lat_d;
      d_out_q     <= d_out_d;
      ptr_q       <= ptr_d;
      imr_q       <= imr_d;
      vec_base_q  <= vec_base_d;
      icw3_q      <= icw3_d;
      ltim_q      <= ltim_d;
      sngl_q      <= sngl_d;
      ic4_q       <= ic4_d;
      icw4_q      <= icw4_d;
      ocw2_cmd_q  <= ocw2_cmd_d;
      ocw2_stb_q  <= ocw2_stb_d;
      smm_q       <= smm_d;
      ris_q       <= ris_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.d_oe  = rd_q;
  assign imr       = imr_q;
  assign vec_base  = vec_base_q;
  assign icw3      = icw3_q;
  assign ltim      = ltim_q;
  assign sngl      = sngl_q;
  assign ic4       = ic4_q;
  assign upm       = icw4_q[0];
  assign aeoi      = icw4_q[1];
  assign ms        = icw4_q[2];
  assign buf_mode  = icw4_q[3];
  assign sfnm      = icw4_q[4];
  assign ocw2_cmd  = ocw2_cmd_q;
  assign ocw2_stb  = ocw2_stb_q;
  assign smm       = smm_q;
  assign ris       = ris_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_pic_cmd_seq.sv
// Directed bench: one 16-channel and one 8-channel sequencer share the same
// CPU bus stimulus; outputs are checked against hand-computed values.
module tb_pic_cmd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic csn = 1'b1, rdn = 1'b1, wrn = 1'b1, a0 = 1'b0;
  logic [7:0]  d_in = '0;
  logic [15:0] irr16 = 16'h1234, isr16 = 16'h8001;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pic_cmd_seq_if bif16 ();
  pic_cmd_seq_if bif8 ();
  assign bif16.csn = csn;  assign bif16.rdn = rdn;  assign bif16.wrn = wrn;
  assign bif16.a0  = a0;   assign bif16.d_in = d_in;
  assign bif8.csn  = csn;  assign bif8.rdn  = rdn;  assign bif8.wrn  = wrn;
  assign bif8.a0   = a0;   assign bif8.d_in  = d_in;

  logic [15:0] imr16;
  logic [4:0]  vb16;
  logic [7:0]  icw3_16, cmd16;
  logic ltim16, sngl16, ic4_16, upm16, aeoi16, ms16, buf16, sfnm16;
  logic stb16, smm16, ris16, done16;

  logic [7:0]  imr8;
  logic [4:0]  vb8;
  logic [7:0]  icw3_8, cmd8;
  logic ltim8, sngl8, ic4_8, upm8, aeoi8, ms8, buf8, sfnm8;
  logic stb8, smm8, ris8, done8;

  pic_cmd_seq #(.NIRQ(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bif16.slave), .irr(irr16), .isr(isr16),
    .imr(imr16), .vec_base(vb16), .icw3(icw3_16), .ltim(ltim16), .sngl(sngl16),
    .ic4(ic4_16), .upm(upm16), .aeoi(aeoi16), .ms(ms16), .buf_mode(buf16),
    .sfnm(sfnm16), .ocw2_cmd(cmd16), .ocw2_stb(stb16), .smm(smm16), .ris(ris16),
    .init_done(done16)
  );

  pic_cmd_seq #(.NIRQ(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bif8.slave), .irr(irr16[7:0]), .isr(isr16[7:0]),
    .imr(imr8), .vec_base(vb8), .icw3(icw3_8), .ltim(ltim8), .sngl(sngl8),
    .ic4(ic4_8), .upm(upm8), .aeoi(aeoi8), .ms(ms8), .buf_mode(buf8),
    .sfnm(sfnm8), .ocw2_cmd(cmd8), .ocw2_stb(stb8), .smm(smm8), .ris(ris8),
    .init_done(done8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle write pulse; returns #1 after the commit edge.
  task automatic bus_write(input logic a, input logic [7:0] d);
    @(posedge clk); #1;
    csn = 1'b0; wrn = 1'b0; a0 = a; d_in = d;
    @(posedge clk); #1;
    csn = 1'b1; wrn = 1'b1;
    @(posedge clk); #1;
    $display("WR a0=%0d d=0x%02h imr16=0x%04h done=%0d", a, d, imr16, done16);
  endtask

  task automatic bus_read(input string tag, input logic a, input logic [7:0] exp16,
                          input logic [7:0] exp8);
    @(posedge clk); #1;
    csn = 1'b0; rdn = 1'b0; a0 = a;
    check_eq({tag, "_oe_pre"}, bif16.d_oe, 0);
    @(posedge clk); #1;
    check_eq({tag, "_oe"}, bif16.d_oe, 1);
    check_eq({tag, "_d16"}, bif16.d_out, exp16);
    check_eq({tag, "_d8"}, bif8.d_out, exp8);
    csn = 1'b1; rdn = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_oe_post"}, bif16.d_oe, 0);
    $display("RD a0=%0d d16=0x%02h d8=0x%02h", a, bif16.d_out, bif8.d_out);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check_eq("rst_imr", imr16, 0);
    check_eq("rst_done", done16, 0);
    check_eq("rst_oe", bif16.d_oe, 0);
    check_eq("rst_dout", bif16.d_out, 0);
    check_eq("rst_vb", vb16, 0);

    // IDLE ignores everything but ICW1
    bus_write(1'b1, 8'hFF);
    check_eq("idle_imr", imr16, 0);
    bus_write(1'b0, 8'h20);
    check_eq("idle_stb", stb16, 0);
    check_eq("idle_cmd", cmd16, 0);

    // Single, with ICW4: W_ICW3 skipped
    bus_write(1'b0, 8'h13);
    check_eq("icw1a_sngl", sngl16, 1);
    check_eq("icw1a_ic4", ic4_16, 1);
    check_eq("icw1a_done", done16, 0);
    bus_write(1'b1, 8'h48);
    check_eq("icw2a_vb", vb16, 5'h09);
    check_eq("icw2a_done", done16, 0);
    bus_write(1'b1, 8'h03);
    check_eq("icw4a_upm", upm16, 1);
    check_eq("icw4a_aeoi", aeoi16, 1);
    check_eq("icw4a_ms", ms16, 0);
    check_eq("icw4a_done", done16, 1);

    // Cascade, no ICW4: ICW4 outputs cleared
    bus_write(1'b0, 8'h10);
    check_eq("icw1b_upm", upm16, 0);
    check_eq("icw1b_aeoi", aeoi16, 0);
    check_eq("icw1b_done", done16, 0);
    bus_write(1'b1, 8'h20);
    check_eq("icw2b_vb", vb16, 5'h04);
    check_eq("icw2b_done", done16, 0);
    bus_write(1'b1, 8'h04);
    check_eq("icw3b_icw3", icw3_16, 8'h04);
    check_eq("icw3b_done", done16, 1);
    check_eq("icw3b_done8", done8, 1);

    // OCW1 byte sequencing and wrap
    bus_write(1'b1, 8'hAA);
    check_eq("ocw1_0_16", imr16, 16'h00AA);
    check_eq("ocw1_0_8", imr8, 8'hAA);
    bus_write(1'b1, 8'h55);
    check_eq("ocw1_1_16", imr16, 16'h55AA);
    check_eq("ocw1_1_8", imr8, 8'h55);
    bus_write(1'b1, 8'h0F);
    check_eq("ocw1_wrap16", imr16, 16'h550F);
    check_eq("ocw1_wrap8", imr8, 8'h0F);

    // OCW2 pulse and pointer reset
    bus_write(1'b0, 8'h20);
    check_eq("ocw2_stb", stb16, 1);
    check_eq("ocw2_cmd", cmd16, 8'h20);
    @(posedge clk); #1;
    check_eq("ocw2_stb_low", stb16, 0);
    bus_write(1'b1, 8'h77);
    check_eq("ocw2_ptr16", imr16, 16'h5577);
    check_eq("ocw2_ptr8", imr8, 8'h77);

    // OCW3 read select and status reads
    bus_write(1'b0, 8'h0B);
    check_eq("ocw3_ris", ris16, 1);
    bus_read("rd_isr0", 1'b0, 8'h01, 8'h01);
    bus_read("rd_isr1", 1'b0, 8'h80, 8'h01);
    bus_write(1'b0, 8'h0A);
    check_eq("ocw3_ris0", ris16, 0);
    bus_read("rd_irr0", 1'b0, 8'h34, 8'h34);
    bus_read("rd_imr1", 1'b1, 8'h55, 8'h77);
    bus_write(1'b0, 8'h68);
    check_eq("ocw3_smm", smm16, 1);

    // Restart from W_ICW3
    bus_write(1'b0, 8'h10);
    check_eq("rst1_smm", smm16, 0);
    bus_write(1'b1, 8'h20);
    bus_write(1'b0, 8'h11);
    check_eq("restart_imr", imr16, 0);
    check_eq("restart_done", done16, 0);
    bus_write(1'b0, 8'h20);
    check_eq("wicw_ign_stb", stb16, 0);
    bus_write(1'b1, 8'hF8);
    check_eq("restart_vb", vb16, 5'h1F);
    bus_write(1'b1, 8'h09);
    check_eq("restart_icw3", icw3_16, 8'h09);
    check_eq("restart_done_mid", done16, 0);
    bus_write(1'b1, 8'h1F);
    check_eq("restart_sfnm", sfnm16, 1);
    check_eq("restart_buf", buf16, 1);
    check_eq("restart_done_end", done16, 1);
    bus_write(1'b1, 8'hC3);
    check_eq("pre_rst_imr", imr16, 16'h00C3);

    // Asynchronous reset in the middle of a held write
    @(posedge clk); #1;
    csn = 1'b0; wrn = 1'b0; a0 = 1'b0; d_in = 8'h13;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_imr", imr16, 0);
    check_eq("arst_done", done16, 0);
    check_eq("arst_vb", vb16, 0);
    check_eq("arst_icw3", icw3_16, 0);
    check_eq("arst_ic4", ic4_16, 0);
    check_eq("arst_sfnm", sfnm16, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("arst_nocommit_sngl", sngl16, 0);
    check_eq("arst_nocommit_ic4", ic4_16, 0);
    csn = 1'b1; wrn = 1'b1;
    @(posedge clk); #1;
    $display("WR held-through-reset a0=0 d=0x13 sngl=%0d ic4=%0d", sngl16, ic4_16);
    check_eq("arst_new_sngl", sngl16, 1);
    check_eq("arst_new_ic4", ic4_16, 1);
    check_eq("arst_new_done", done16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/pic_cmd_seq.md
# pic_cmd_seq

Parametrised command-word sequencer and CPU bus interface for the interrupt controller. It decodes CPU read and write cycles from `csn`, `rdn`, `wrn` and `a0`. It runs the ICW1→ICW2→ICW3→ICW4 initialisation state machine, then accepts OCW1–OCW3 and returns IRR/ISR/IMR status. It sits between the CPU data bus pins and the priority resolver and in-service logic, and supports channel counts above 8 through byte-sequenced mask writes and status reads.

## Interface
- `NIRQ`, 8, number of interrupt channels; must be a multiple of 8, range 8–32; NB = NIRQ/8 bytes.
- `clk`  in  1  system clock; all bus inputs are synchronous to it.
- `rst_n`  in  1  asynchronous, active-low reset.
- `csn`, `rdn`, `wrn`  in  1 each  active-low chip select, read strobe and write strobe.
- `a0`  in  1  address bit.
- `d_in`  in  8  CPU write data.
- `d_out`  out  8  CPU read data, registered.
- `d_oe`  out  1  pad driver enable for `d_out`.
- `irr`, `isr`  in  NIRQ each  request and in-service vectors from the core.
- `imr`  out  NIRQ  interrupt mask.
- `vec_base`  out  5  ICW2[7:3].
- `icw3`  out  8  cascade word.
- `ltim`, `sngl`, `ic4`  out  1 each  ICW1 bits 3, 1, 0.
- `upm`, `aeoi`, `ms`, `buf_mode`, `sfnm`  out  1 each  ICW4 bits 0–4.
- `ocw2_cmd`  out  8  last OCW2 byte.
- `ocw2_stb`  out  1  one-cycle pulse per accepted OCW2.
- `smm`  out  1  special mask mode.
- `ris`  out  1  read-select: 0 = IRR, 1 = ISR.
- `init_done`  out  1  high in READY.

## Operation
- Reset: state IDLE. Every output and register is 0, including `imr`, `ptr`, `d_oe`, `d_out` and `init_done`.
- States are IDLE, W_ICW2, W_ICW3, W_ICW4 and READY.
- **ICW1** is a write with a0=0 and d[4]=1. It is accepted in every state and always restarts initialisation:
  - latches `ltim`, `sngl` and `ic4`;
  - clears `imr`, `smm`, `ris` and `ptr`;
  - clears all ICW4 outputs when d[0]=0;
  - sets `init_done` to 0;
  - next state is W_ICW2.
- **ICW2, ICW3, ICW4** are writes with a0=1:
  - In W_ICW2, `vec_base` ← d[7:3]. Next state is W_ICW3 if `sngl`=0, else W_ICW4 if `ic4`=1, else READY.
  - In W_ICW3, `icw3` ← d. Next state is W_ICW4 if `ic4`, else READY.
  - In W_ICW4, the ICW4 bits are latched. Next state is READY.
  - In W_ICW* states, a0=0 writes other than ICW1 are ignored.
- In IDLE, everything except ICW1 is ignored.
- **OCW1** (READY, a0=1):
  - `imr[8*ptr +: 8]` ← d.
  - `ptr` ← `ptr`+1, wrapping NB-1 → 0. With NIRQ=8, `ptr` stays 0.
- **OCW2** (READY, a0=0, d[4:3]=00):
  - `ocw2_cmd` ← d; `ocw2_stb` pulses; `ptr` ← 0.
- **OCW3** (READY, a0=0, d[4:3]=01):
  - if d[1]=1, `ris` ← d[0];
  - if d[6]=1, `smm` ← d[5];
  - `ptr` ← 0.
- **Reads** are legal in every state:
  - a0=1 returns `imr` byte `ptr`.
  - a0=0 returns byte `ptr` of `isr` if `ris`=1, else of `irr`.
  - Each completed read advances `ptr` with the same wrap rule.
- `ptr` is shared between OCW1 writes and reads.
- Simultaneous `rdn` and `wrn` low with `csn` low is a protocol violation. The write takes precedence and the read is suppressed.

## Timing
- `wr_act` = ~csn & ~wrn & rdn-state-independent. `rd_act` = ~csn & ~rdn & wrn.
- Both are registered each cycle into `wr_q` and `rd_q`.
- `d_lat` ← `d_in` on every cycle with `wr_act`=1.
- **Write commit** happens on the trailing edge of the write cycle, at the first clk edge where `wr_q`=1 and `wr_act`=0.
  - State and register updates, including `ocw2_stb`=1, become visible the cycle after that edge.
  - `ocw2_stb` stays high for exactly 1 cycle.
  - Minimum write pulse: 1 cycle. A 1-cycle pulse commits at the following edge.
- **Read timing**:
  - `d_oe` = `rd_q`, so it rises 1 cycle after `rd_act` rises and falls 1 cycle after it falls.
  - `d_out` is loaded while `rd_act`=1, so it tracks live `irr`/`isr`.
  - `ptr` increments on the read trailing edge, using the same detection as writes.
- If `csn` deasserts while `wrn` is still low, that also counts as a trailing edge and the write commits.
- **Asynchronous reset mid-cycle**:
  - all outputs are zero immediately;
  - `wr_q` and `rd_q` are cleared, so the interrupted cycle never commits;
  - strobes held low through reset release are treated as new cycles.

## Test plan
- NIRQ=8. Write ICW1=0x13 (sngl, ic4), then ICW2=0x48, then ICW4=0x03 → W_ICW3 is skipped; `vec_base`=0x09, `aeoi`=1, `upm`=1, `init_done`=1 after the third commit.
- Write ICW1=0x10, then ICW2=0x20 → `sngl`=0 and `ic4`=0, so the next state is W_ICW3. Write ICW3=0x04 → state READY, `icw3`=0x04, all ICW4 outputs 0.
- NIRQ=16, READY. Write OCW1 0xAA then 0x55 → `imr`=0x55AA. A third OCW1 of 0x0F (wrapped) → `imr`=0x550F. Then OCW2=0x20 → `ocw2_stb` is 1 cycle high, `ocw2_cmd`=0x20, `ptr`=0.
- NIRQ=16. Write OCW3=0x0B, drive `isr`=0x8001, then do 2 reads at a0=0 → data 0x01 then 0x80, with `d_oe` high 1 cycle after each `rdn` fall. Write OCW3=0x0A, then read → returns the `irr` low byte.
- Mid-init ICW1 restart: in W_ICW3, write ICW1=0x11 → state W_ICW2, `imr`=0, `init_done`=0. In IDLE, an OCW1 write is ignored and `imr` stays 0.
- Assert `rst_n` low during a write with `wrn` held low → all outputs 0 immediately. Release `rst_n`, then release `wrn` → a commit is observed only for the new cycle, never for the interrupted one.
